// File: rtl/cjtag_pkg.sv
// Shared encodings and thresholds for the cJTAG-to-JTAG bridge.
package cjtag_pkg;

    typedef enum logic [1:0] {
        ST_OFFLINE  = 2'd0,
        ST_ACTIVATE = 2'd1,
        ST_ONLINE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PH_NTDI = 2'd0,
        PH_TMS  = 2'd1,
        PH_TDO  = 2'd2
    } phase_e;

    localparam int unsigned ESC_DESELECT = 4;
    localparam int unsigned ESC_SELECT   = 6;
    localparam int unsigned ESC_RESET    = 8;

    localparam int unsigned ACT_BITS = 12;
    localparam logic [ACT_BITS-1:0] ACT_CODE_DEFAULT = 12'b0000_1000_1100;

endpackage

// File: rtl/cjtag_pin_sync.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall strobes.
module cjtag_pin_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Strobes are decoded straight from the register pair so the consumer registers the decision.
    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/cjtag_tap_bridge.sv
// cJTAG target endpoint: escape/activation decode and OScan1 frames to a four-wire TAP.
module cjtag_tap_bridge
    import cjtag_pkg::*;
#(
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [ACT_BITS-1:0]  ACT_CODE    = ACT_CODE_DEFAULT,
    parameter int unsigned          HALT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic RES,
    input  logic TCKC,
    input  logic TMSC_I,
    output logic TMSC_O,
    output logic TMSC_E,
    output logic JTAG_TCK,
    output logic JTAG_TMS,
    output logic JTAG_TDI,
    input  logic JTAG_TDO,
    output logic TAP_RESET,
    output logic ONLINE,
    output logic HALT_REQ
);

    localparam int unsigned ESC_W  = 4;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned HALT_W = 18;

    logic tck, tck_rise, tck_fall;
    logic tms, tms_rise, tms_fall;

    cjtag_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_tckc (
        .clk_i(CLK), .rst_i(RES), .pin_i(TCKC),
        .level_o(tck), .rise_o(tck_rise), .fall_o(tck_fall)
    );

    cjtag_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_tmsc (
        .clk_i(CLK), .rst_i(RES), .pin_i(TMSC_I),
        .level_o(tms), .rise_o(tms_rise), .fall_o(tms_fall)
    );

    state_e              state_q;
    phase_e              phase_q;
    logic [ESC_W-1:0]    esc_cnt_q;
    logic [ACT_BITS-1:0] shift_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [HALT_W-1:0]   halt_cnt_q;
    logic                ntdi_q, tms_cap_q;
    logic                jtag_tck_q, jtag_tms_q, jtag_tdi_q;
    logic                tmsc_o_q, tmsc_e_q, tap_reset_q, online_q, halt_q;

    logic tms_edge_c, esc_any_c, halt_hold_c, tmsc_e_d;

    assign tms_edge_c  = tms_rise | tms_fall;
    assign esc_any_c   = tck_fall && (esc_cnt_q >= ESC_W'(ESC_DESELECT));
    assign halt_hold_c = tck & ~tms & ~tck_rise & ~tck_fall & ~tms_edge_c;
    // TMSC is driven from the P1->P2 fall until the P2 fall or any escape.
    assign tmsc_e_d    = (state_q == ST_ONLINE) &&
                         (tck_fall ? (!esc_any_c && phase_q == PH_TMS) : tmsc_e_q);

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q     <= ST_OFFLINE;
            phase_q     <= PH_NTDI;
            esc_cnt_q   <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            halt_cnt_q  <= '0;
            ntdi_q      <= 1'b0;
            tms_cap_q   <= 1'b1;
            jtag_tck_q  <= 1'b0;
            jtag_tms_q  <= 1'b1;
            jtag_tdi_q  <= 1'b0;
            tmsc_o_q    <= 1'b0;
            tmsc_e_q    <= 1'b0;
            tap_reset_q <= 1'b0;
            online_q    <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            tap_reset_q <= 1'b0;
            online_q    <= (state_q == ST_ONLINE) && !esc_any_c;
            tmsc_e_q    <= tmsc_e_d;
            tmsc_o_q    <= tmsc_e_d & JTAG_TDO;

            if (tck_fall) begin
                esc_cnt_q <= '0;
            end else if (tck && tms_edge_c && esc_cnt_q != '1) begin
                esc_cnt_q <= esc_cnt_q + ESC_W'(1);
            end

            if (!halt_hold_c) begin
                halt_cnt_q <= '0;
            end else if (halt_cnt_q != '1) begin
                halt_cnt_q <= halt_cnt_q + HALT_W'(1);
            end

            if (tck_fall || tms_rise) begin
                halt_q <= 1'b0;
            end else if (halt_hold_c && halt_cnt_q >= HALT_W'(HALT_CYCLES - 1)) begin
                halt_q <= 1'b1;
            end

            if (tck_rise) begin
                case (state_q)
                    ST_ACTIVATE: begin
                        if (bit_cnt_q != BIT_W'(ACT_BITS)) begin
                            shift_q   <= {tms, shift_q[ACT_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                    ST_ONLINE: begin
                        if (phase_q == PH_NTDI) ntdi_q <= tms;
                        else if (phase_q == PH_TMS) tms_cap_q <= tms;
                    end
                    default: ;
                endcase
            end

            if (tck_fall) begin
                if (esc_any_c) begin
                    jtag_tck_q <= 1'b0;
                    phase_q    <= PH_NTDI;
                    if (esc_cnt_q >= ESC_W'(ESC_RESET)) begin
                        state_q     <= ST_OFFLINE;
                        tap_reset_q <= 1'b1;
                    end else if (esc_cnt_q >= ESC_W'(ESC_SELECT)) begin
                        state_q   <= ST_ACTIVATE;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        state_q <= ST_OFFLINE;
                    end
                end else begin
                    case (state_q)
                        ST_ACTIVATE: begin
                            if (bit_cnt_q == BIT_W'(ACT_BITS)) begin
                                state_q <= (shift_q == ACT_CODE) ? ST_ONLINE : ST_OFFLINE;
                                phase_q <= PH_NTDI;
                            end
                        end
                        ST_ONLINE: begin
                            case (phase_q)
                                PH_NTDI: phase_q <= PH_TMS;
                                PH_TMS: begin
                                    phase_q    <= PH_TDO;
                                    jtag_tdi_q <= ~ntdi_q;
                                    jtag_tms_q <= tms_cap_q;
                                    jtag_tck_q <= 1'b1;
                                end
                                default: begin
                                    phase_q    <= PH_NTDI;
                                    jtag_tck_q <= 1'b0;
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign TMSC_O    = tmsc_o_q;
    assign TMSC_E    = tmsc_e_q;
    assign JTAG_TCK  = jtag_tck_q;
    assign JTAG_TMS  = jtag_tms_q;
    assign JTAG_TDI  = jtag_tdi_q;
    assign TAP_RESET = tap_reset_q;
    assign ONLINE    = online_q;
    assign HALT_REQ  = halt_q;

endmodule

// File: tb/tb_cjtag_tap_bridge.sv
// Directed bench for cjtag_tap_bridge: activation, frames, escapes, halt request, reset.
module tb_cjtag_tap_bridge;

    logic CLK = 1'b0;
    logic RES, TCKC, TMSC_I, JTAG_TDO;
    logic TMSC_O, TMSC_E, JTAG_TCK, JTAG_TMS, JTAG_TDI, TAP_RESET, ONLINE, HALT_REQ;

    int vecs = 0;
    int errs = 0;
    int tck_pulses = 0;
    int rst_cycles = 0;
    int e_cycles   = 0;
    logic tck_prev = 1'b0;

    localparam logic [11:0] ACT = 12'b0000_1000_1100;

    cjtag_tap_bridge dut (
        .CLK(CLK), .RES(RES), .TCKC(TCKC), .TMSC_I(TMSC_I),
        .TMSC_O(TMSC_O), .TMSC_E(TMSC_E),
        .JTAG_TCK(JTAG_TCK), .JTAG_TMS(JTAG_TMS), .JTAG_TDI(JTAG_TDI), .JTAG_TDO(JTAG_TDO),
        .TAP_RESET(TAP_RESET), .ONLINE(ONLINE), .HALT_REQ(HALT_REQ)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (JTAG_TCK && !tck_prev) tck_pulses <= tck_pulses + 1;
        tck_prev <= JTAG_TCK;
        if (TAP_RESET) rst_cycles <= rst_cycles + 1;
        if (TMSC_E) e_cycles <= e_cycles + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic tck_high(input logic b);
        TMSC_I = b;
        cyc(3);
        TCKC = 1'b1;
        cyc(6);
    endtask

    task automatic bit_cycle(input logic b);
        tck_high(b);
        TCKC = 1'b0;
        cyc(6);
    endtask

    task automatic escape(input int n);
        TCKC = 1'b1;
        cyc(6);
        repeat (n) begin
            TMSC_I = ~TMSC_I;
            cyc(6);
        end
        TCKC = 1'b0;
        cyc(6);
    endtask

    task automatic send_code(input logic [11:0] code);
        for (int i = 0; i < 12; i++) bit_cycle(code[i]);
    endtask

    task automatic do_reset();
        RES = 1'b1; TCKC = 1'b0; TMSC_I = 1'b1; JTAG_TDO = 1'b0;
        cyc(3);
        RES = 1'b0;
        cyc(4);
    endtask

    task automatic go_online();
        escape(6);
        send_code(ACT);
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if ({TMSC_O, TMSC_E, JTAG_TCK, JTAG_TMS, JTAG_TDI, TAP_RESET, ONLINE, HALT_REQ} !== 8'b0001_0000) begin
            errs++;
            $display("FAIL reset_values: got %b exp 00010000",
                     {TMSC_O, TMSC_E, JTAG_TCK, JTAG_TMS, JTAG_TDI, TAP_RESET, ONLINE, HALT_REQ});
        end
    endtask

    task automatic test_activate();
        int e0;
        do_reset();
        e0 = e_cycles;
        escape(6);
        for (int i = 0; i < 11; i++) bit_cycle(ACT[i]);
        vecs++;
        if (ONLINE !== 1'b0) begin errs++; $display("FAIL act_11bits: ONLINE got %b exp 0", ONLINE); end
        tck_high(ACT[11]);
        TCKC = 1'b0;
        cyc(3);
        vecs++;
        if (ONLINE !== 1'b0) begin errs++; $display("FAIL act_decision_cycle: ONLINE got %b exp 0", ONLINE); end
        cyc(1);
        vecs++;
        if (ONLINE !== 1'b1) begin errs++; $display("FAIL act_online: ONLINE got %b exp 1", ONLINE); end
        cyc(5);
        vecs++;
        if (e_cycles != e0) begin errs++; $display("FAIL act_tmsc_e: enable cycles got %0d exp 0", e_cycles - e0); end
    endtask

    task automatic frame_check(input logic ntdi, input logic tmsv, input logic tdo, input string nm);
        int p0;
        p0 = tck_pulses;
        JTAG_TDO = tdo;
        bit_cycle(ntdi);
        vecs++;
        if ({JTAG_TCK, TMSC_E} !== 2'b00) begin
            errs++; $display("FAIL %s_p1: tck,e got %b exp 00", nm, {JTAG_TCK, TMSC_E});
        end
        bit_cycle(tmsv);
        vecs++;
        if ({JTAG_TCK, JTAG_TDI, JTAG_TMS, TMSC_E, TMSC_O} !== {1'b1, ~ntdi, tmsv, 1'b1, tdo}) begin
            errs++; $display("FAIL %s_p2: tck,tdi,tms,e,o got %b exp %b", nm,
                             {JTAG_TCK, JTAG_TDI, JTAG_TMS, TMSC_E, TMSC_O}, {1'b1, ~ntdi, tmsv, 1'b1, tdo});
        end
        JTAG_TDO = ~tdo;
        cyc(1);
        vecs++;
        if (TMSC_O !== ~tdo) begin errs++; $display("FAIL %s_tdo_follow: TMSC_O got %b exp %b", nm, TMSC_O, ~tdo); end
        tck_high(TMSC_I);
        TCKC = 1'b0;
        cyc(2);
        vecs++;
        if ({JTAG_TCK, TMSC_E} !== 2'b11) begin
            errs++; $display("FAIL %s_p2_hold: tck,e got %b exp 11", nm, {JTAG_TCK, TMSC_E});
        end
        cyc(1);
        vecs++;
        if ({JTAG_TCK, TMSC_E, TMSC_O} !== 3'b000) begin
            errs++; $display("FAIL %s_p2_end: tck,e,o got %b exp 000", nm, {JTAG_TCK, TMSC_E, TMSC_O});
        end
        cyc(3);
        vecs++;
        if (tck_pulses - p0 != 1) begin errs++; $display("FAIL %s_pulses: got %0d exp 1", nm, tck_pulses - p0); end
    endtask

    task automatic test_frame();
        frame_check(1'b0, 1'b1, 1'b1, "frame_a");
    endtask

    task automatic test_back_to_back();
        frame_check(1'b1, 1'b0, 1'b0, "frame_b");
        vecs++;
        if (ONLINE !== 1'b1) begin errs++; $display("FAIL b2b_online: got %b exp 1", ONLINE); end
    endtask

    task automatic test_bad_code();
        int p0;
        logic [11:0] bad;
        do_reset();
        bad = ACT ^ 12'h020;
        escape(6);
        send_code(bad);
        cyc(4);
        vecs++;
        if (ONLINE !== 1'b0) begin errs++; $display("FAIL badcode_online: got %b exp 0", ONLINE); end
        p0 = tck_pulses;
        bit_cycle(1'b0); bit_cycle(1'b1); bit_cycle(1'b0);
        vecs++;
        if (tck_pulses != p0) begin errs++; $display("FAIL badcode_tck: pulses got %0d exp 0", tck_pulses - p0); end
    endtask

    task automatic test_escapes();
        int r0, p0;
        do_reset();
        go_online();
        r0 = rst_cycles;
        escape(9);
        vecs++;
        if (rst_cycles - r0 != 1) begin errs++; $display("FAIL esc9_tap_reset: cycles got %0d exp 1", rst_cycles - r0); end
        vecs++;
        if (ONLINE !== 1'b0) begin errs++; $display("FAIL esc9_online: got %b exp 0", ONLINE); end
        go_online();
        vecs++;
        if (ONLINE !== 1'b1) begin errs++; $display("FAIL reselect_online: got %b exp 1", ONLINE); end
        r0 = rst_cycles;
        escape(4);
        vecs++;
        if (ONLINE !== 1'b0 || rst_cycles != r0) begin
            errs++; $display("FAIL esc4_deselect: online got %b resets %0d exp 0 0", ONLINE, rst_cycles - r0);
        end
        p0 = tck_pulses;
        bit_cycle(1'b0); bit_cycle(1'b1); bit_cycle(1'b0);
        vecs++;
        if (tck_pulses != p0) begin errs++; $display("FAIL esc4_offline_tck: pulses got %0d exp 0", tck_pulses - p0); end
    endtask

    task automatic test_halt();
        do_reset();
        TMSC_I = 1'b0;
        cyc(6);
        TCKC = 1'b1;
        cyc(1026);
        vecs++;
        if (HALT_REQ !== 1'b0) begin errs++; $display("FAIL halt_1023: got %b exp 0", HALT_REQ); end
        cyc(1);
        vecs++;
        if (HALT_REQ !== 1'b1) begin errs++; $display("FAIL halt_1024: got %b exp 1", HALT_REQ); end
        TCKC = 1'b0;
        cyc(2);
        vecs++;
        if (HALT_REQ !== 1'b1) begin errs++; $display("FAIL halt_hold: got %b exp 1", HALT_REQ); end
        cyc(1);
        vecs++;
        if (HALT_REQ !== 1'b0) begin errs++; $display("FAIL halt_clear: got %b exp 0", HALT_REQ); end
        cyc(4);
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        do_reset();
        go_online();
        JTAG_TDO = 1'b1;
        bit_cycle(1'b0);
        bit_cycle(1'b1);
        vecs++;
        if ({JTAG_TCK, TMSC_E} !== 2'b11) begin errs++; $display("FAIL midrst_p2: tck,e got %b exp 11", {JTAG_TCK, TMSC_E}); end
        RES = 1'b1;
        #1;
        vecs++;
        if ({JTAG_TCK, TMSC_E, TMSC_O, ONLINE, JTAG_TMS, JTAG_TDI} !== 6'b000010) begin
            errs++; $display("FAIL midrst_async: tck,e,o,online,tms,tdi got %b exp 000010",
                             {JTAG_TCK, TMSC_E, TMSC_O, ONLINE, JTAG_TMS, JTAG_TDI});
        end
        cyc(2);
        RES = 1'b0;
        cyc(4);
        p0 = tck_pulses;
        bit_cycle(1'b0); bit_cycle(1'b1); bit_cycle(1'b0);
        vecs++;
        if (tck_pulses != p0 || ONLINE !== 1'b0) begin
            errs++; $display("FAIL midrst_offline: pulses %0d online %b exp 0 0", tck_pulses - p0, ONLINE);
        end
    endtask

    initial begin
        RES = 1'b1; TCKC = 1'b0; TMSC_I = 1'b1; JTAG_TDO = 1'b0;
        test_reset();
        test_activate();
        test_frame();
        test_back_to_back();
        test_bad_code();
        test_escapes();
        test_halt();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
